// File: rtl/load_store_unit.sv
// RV32I load/store unit: drives data-memory read/write cycles,
// extracts LB/LH/LW/LBU/LHU results and merges SB/SH via read-modify-write.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_data_in,
  input  logic        mem_Ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RMW_RD,
    S_WR,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [2:0]         r_f3;
  logic [31:0]        r_addr;
  logic [15:0]        r_wdata;
  logic               r_err;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_load_data;
  logic [31:0]        r_wr_data;

  logic               w_illegal;
  logic               w_misal;
  logic               w_bad;
  logic               w_tmo;
  logic [4:0]         w_bsh;
  logic [4:0]         w_hsh;
  logic [31:0]        w_bword;
  logic [31:0]        w_hword;
  logic [31:0]        w_ext;
  logic [31:0]        w_merge;

  // classify the incoming request: illegal funct3 or misaligned address
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    unique case (1'b1)
      req_is_store:
        w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      default:
        w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    endcase
    if (req_funct3[1:0] == 2'b01)
      w_misal = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      w_misal = (req_addr[1:0] != 2'b00);
  end

  assign w_bad   = w_illegal || w_misal;
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_bsh   = {r_addr[1:0], 3'b000};
  assign w_hsh   = {r_addr[1], 4'b0000};
  assign w_bword = mem_data_in >> w_bsh;
  assign w_hword = mem_data_in >> w_hsh;

  // lane extraction with sign/zero extension for loads
  always_comb begin
    w_ext = mem_data_in;
    unique case (r_f3)
      3'b000:  w_ext = {{24{w_bword[7]}}, w_bword[7:0]};
      3'b001:  w_ext = {{16{w_hword[15]}}, w_hword[15:0]};
      3'b100:  w_ext = {24'h0, w_bword[7:0]};
      3'b101:  w_ext = {16'h0, w_hword[15:0]};
      default: w_ext = mem_data_in;
    endcase
  end

  // byte/half lane replacement for the RMW write word
  always_comb begin
    w_merge = mem_data_in;
    if (r_f3[1:0] == 2'b00)
      w_merge = (mem_data_in & ~(32'h0000_00ff << w_bsh))
              | ({24'h0, r_wdata[7:0]} << w_bsh);
    else
      w_merge = (mem_data_in & ~(32'h0000_ffff << w_hsh))
              | ({16'h0, r_wdata} << w_hsh);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic and strobes
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    mem_MemRead  = 1'b0;
    mem_MemWrite = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_bad)                      w_next = S_RESP;
          else if (!req_is_store)         w_next = S_RD;
          else if (req_funct3 == 3'b010)  w_next = S_WR;
          else                            w_next = S_RMW_RD;
        end
      end
      S_RD: begin
        mem_MemRead = 1'b1;
        if (mem_Ready || w_tmo) w_next = S_RESP;
      end
      S_RMW_RD: begin
        mem_MemRead = 1'b1;
        if (mem_Ready)  w_next = S_WR;
        else if (w_tmo) w_next = S_RESP;
      end
      S_WR: begin
        mem_MemWrite = 1'b1;
        w_next       = S_RESP;
      end
      S_RESP: begin
        done   = 1'b1;
        err    = r_err;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // request latch, timeout counter, load result and write word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_f3        <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= '0;
      r_wr_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (req_valid) begin
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata[15:0];
            r_err   <= w_bad;
            if (w_bad && !req_is_store)
              r_load_data <= '0;
            if (!w_bad && req_is_store && req_funct3 == 3'b010)
              r_wr_data <= req_wdata;
          end
        end
        S_RD: begin
          if (mem_Ready) begin
            r_load_data <= w_ext;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_tmo) begin
              r_err       <= 1'b1;
              r_load_data <= '0;
            end
          end
        end
        S_RMW_RD: begin
          if (mem_Ready) begin
            r_wr_data <= w_merge;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_tmo) r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_data      = r_load_data;
  assign mem_address    = {r_addr[31:2], 2'b00};
  assign mem_write_data = r_wr_data;

endmodule
